red_tree_collector: RTL and testbench
=====================================

# red_tree_collector

Downstream collector for the reduction tree. Captures one frame of N-1 tree node sums, valid flags and vector IDs, then drains only the valid sums in ascending node order through a valid/ready stream to the output buffer. Sits between the reduction tree output and the accumulation/output SRAM writer. It absorbs backpressure so the tree sees a simple frame handshake.

## Interface
- N, 32, operand count of the upstream tree; power of 2, ≥4
- W, 8, operand bit-width
- V, 3, vector-ID bit-width
- S, W+$clog2(N), sum bit-width; must match the tree's output width
- NI, $clog2(N-1), node-index width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  frame present on in_* buses
- in_ready  out  1  collector accepts frame this cycle
- in_sums  in  (N-1)×S  tree node sums, index = tree node index
- in_valids  in  N-1  per-node valid flags
- in_vec_ids  in  (N-1)×V  vector ID owning each node
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_sum  out  S  selected node sum
- out_vec_id  out  V  vector ID of selected node
- out_node  out  NI  node index of selected node
- out_last  out  1  this result is the final one of its frame
- frames_done  out  16  count of fully drained non-empty frames; wraps

## Operation
- FSM states: IDLE, DRAIN. Reset → IDLE.
- Captured state: sum_q[N-1], id_q[N-1], mask_q[N-1].
- In IDLE, in_ready=1. On in_valid, all three captured arrays load. Next state is DRAIN if in_valids≠0. An all-zero frame is consumed silently and the FSM stays IDLE.
- In DRAIN, out_valid=1. A priority encoder selects sel = the lowest set bit of mask_q. It drives out_sum=sum_q[sel], out_vec_id=id_q[sel], out_node=sel.
- out_last=1 when popcount(mask_q)==1.
- On out_valid&&out_ready, bit sel of mask_q clears.
- If the handshaked result was out_last, frames_done increments by 1 (mod 2^16) and the FSM leaves DRAIN.
- in_ready in DRAIN = out_ready && out_last. This makes back-to-back frames bubble-free. If in_valid is high in that same cycle, the new frame is captured and the FSM returns to DRAIN, or goes to IDLE if the new frame's in_valids==0. Otherwise the FSM goes to IDLE.
- out_* are held stable while out_valid&&!out_ready. mask_q does not change without a handshake.
- In IDLE, out_valid=0. out_sum, out_vec_id, out_node and out_last show the selection from mask_q, which is all zero after a drain, so they read 0.
- Sums pass through unmodified; no width change, no arithmetic.

## Timing
- Reset (rst=1 at a clock edge): state=IDLE; mask_q=0; sum_q=0; id_q=0; frames_done=0. Consequently out_valid=0, out_last=0, out_sum=0, out_vec_id=0, out_node=0, in_ready=1.
- Reset mid-DRAIN discards the remaining results; no partial out_last is emitted.
- Latency: a frame accepted at edge t presents its first result from cycle t+1.
- Throughput: one result per cycle with out_ready held high. A frame with k valid nodes occupies exactly k cycles of DRAIN.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready; it is the only ready-to-ready path.
- out_* and out_valid depend only on registers.

## Structure
- Shared package: S/NI width helpers and the FSM state enum (IDLE, DRAIN). Also a typedef for a result record {sum, vec_id, node, last}, reused by the output-buffer writer.
- One sub-module: red_lsb_select. It is combinational: N-1-bit mask in, one-hot grant, binary index and an "exactly one bit set" flag out. Instantiated once.
- Capture registers, mask update, FSM and frames_done counter stay in the top module.

## Test plan
- Reset mid-drain: frame with valids 0x3 (N=32), pull rst after the first result → out_valid=0, mask clear, frames_done unchanged, in_ready=1 next cycle.
- Single frame, out_ready=1: in_valids bits {0,5,30}, sums 10/20/30, IDs 1/2/3 → three consecutive results (node0,10,id1), (node5,20,id2), (node30,30,id3,last). frames_done=1.
- Backpressure: same frame, out_ready low for 4 cycles after the first result → out_* held at node5 values throughout. Drain completes once out_ready rises; in_ready=0 meanwhile.
- Back-to-back: second frame (valid node 2, sum 0x1FFF, ID 7) held on in_valid during the first frame's last handshake. It is captured in that cycle; next cycle out = (node2, 0x1FFF, id7, last) with no bubble.
- Empty frame: in_valids=0 → accepted in one cycle, out_valid stays 0, frames_done unchanged.
- Full frame: all 31 valid, random out_ready → 31 results in ascending node order, exactly one out_last. Outputs match a scoreboard. frames_done wraps 0xFFFF→0 after 65536 such frames (force-preloaded).

Source files
------------

// File: rtl/red_tree_collector_pkg.sv
// rtl/red_tree_collector_pkg.sv - shared widths, FSM state and result record for the reduction-tree collector
package red_tree_collector_pkg;

  localparam int N_DEF = 32;
  localparam int W_DEF = 8;
  localparam int V_DEF = 3;

  function automatic int sum_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

  function automatic int node_idx_width(input int n);
    return $clog2(n - 1);
  endfunction

  localparam int S_DEF  = sum_width(N_DEF, W_DEF);
  localparam int NI_DEF = node_idx_width(N_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // One drained result as seen by the output-buffer writer.
  typedef struct packed {
    logic [S_DEF-1:0]  sum;
    logic [V_DEF-1:0]  vec_id;
    logic [NI_DEF-1:0] node;
    logic              last;
  } result_t;

endpackage

// File: rtl/red_lsb_select.sv
// rtl/red_lsb_select.sv - lowest-set-bit selector: one-hot grant, binary index, single-bit flag
module red_lsb_select #(
  parameter int M  = 31,
  parameter int IW = $clog2(M)
) (
  input  logic [M-1:0]  mask,
  output logic [M-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          one_hot
);

  assign grant   = mask & (~mask + M'(1));
  assign one_hot = (mask != '0) && ((mask & (mask - M'(1))) == '0);

  // Scan high to low so the last hit written is the lowest set bit.
  always_comb begin
    index = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (mask[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/red_tree_collector.sv
// rtl/red_tree_collector.sv - captures one tree frame and drains valid node sums in ascending order
module red_tree_collector
  import red_tree_collector_pkg::*;
#(
  parameter int N  = 32,
  parameter int W  = 8,
  parameter int V  = 3,
  parameter int S  = sum_width(N, W),
  parameter int NI = node_idx_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(N-1)*S-1:0]   in_sums,
  input  logic [N-2:0]         in_valids,
  input  logic [(N-1)*V-1:0]   in_vec_ids,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [S-1:0]         out_sum,
  output logic [V-1:0]         out_vec_id,
  output logic [NI-1:0]        out_node,
  output logic                 out_last,
  output logic [15:0]          frames_done
);

  localparam int M = N - 1;

  state_t          state;
  logic [S-1:0]    sum_q [M];
  logic [V-1:0]    id_q  [M];
  logic [M-1:0]    mask_q;
  logic [M-1:0]    grant;
  logic [NI-1:0]   sel;
  logic            one_left;
  logic            take;
  logic            accept;

  red_lsb_select #(.M(M), .IW(NI)) u_lsb_select (
    .mask    (mask_q),
    .grant   (grant),
    .index   (sel),
    .one_hot (one_left)
  );

  assign out_valid = (state == DRAIN);
  assign out_node  = sel;
  assign out_last  = one_left;
  assign in_ready  = (state == IDLE) || (out_ready && one_left);
  assign take      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  // AND-OR mux on the grant so an empty mask reads as zero.
  always_comb begin
    out_sum    = '0;
    out_vec_id = '0;
    for (int i = 0; i < M; i++) begin
      out_sum    = out_sum | (sum_q[i] & {S{grant[i]}});
      out_vec_id = out_vec_id | (id_q[i] & {V{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      frames_done <= '0;
      for (int i = 0; i < M; i++) begin
        sum_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      if (take) begin
        mask_q <= mask_q & ~grant;
        if (one_left) begin
          frames_done <= frames_done + 16'd1;
          state       <= IDLE;
        end
      end
      // A new frame only lands in DRAIN on the final handshake, so it overrides the clear above.
      if (accept) begin
        for (int i = 0; i < M; i++) begin
          sum_q[i] <= in_sums[i*S +: S];
          id_q[i]  <= in_vec_ids[i*V +: V];
        end
        mask_q <= in_valids;
        state  <= (in_valids != '0) ? DRAIN : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_red_tree_collector.sv
// tb/tb_red_tree_collector.sv - scoreboard bench for red_tree_collector
module tb_red_tree_collector;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int V  = 3;
  localparam int S  = W + $clog2(N);
  localparam int NI = $clog2(N - 1);
  localparam int M  = N - 1;

  typedef logic [S+V+NI:0] exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [M*S-1:0]     in_sums;
  logic [M-1:0]       in_valids;
  logic [M*V-1:0]     in_vec_ids;
  logic               out_valid;
  logic               out_ready;
  logic [S-1:0]       out_sum;
  logic [V-1:0]       out_vec_id;
  logic [NI-1:0]      out_node;
  logic               out_last;
  logic [15:0]        frames_done;

  logic [S-1:0]       f_sum [M];
  logic [V-1:0]       f_id  [M];
  exp_t               sb [$];
  int                 vectors = 0;
  int                 errors  = 0;
  logic [15:0]        exp_done = '0;

  red_tree_collector #(.N(N), .W(W), .V(V)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sums     (in_sums),
    .in_valids   (in_valids),
    .in_vec_ids  (in_vec_ids),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_vec_id  (out_vec_id),
    .out_node    (out_node),
    .out_last    (out_last),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < M; i++) begin
      f_sum[i] = S'($urandom);
      f_id[i]  = V'($urandom);
    end
  endtask

  // Drives a frame and queues the results it should produce, lowest node first.
  task automatic put_frame(input logic [M-1:0] vals);
    int last_i;
    last_i = -1;
    for (int i = 0; i < M; i++) begin
      in_sums[i*S +: S]    = f_sum[i];
      in_vec_ids[i*V +: V] = f_id[i];
      if (vals[i]) last_i = i;
    end
    in_valids = vals;
    in_valid  = 1'b1;
    for (int i = 0; i < M; i++) begin
      if (vals[i]) sb.push_back({f_sum[i], f_id[i], NI'(i), (i == last_i)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    vectors++;
    if ({out_valid, out_last, out_sum, out_vec_id, out_node} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got valid=%b last=%b sum=%h id=%h node=%h, want all 0",
               out_valid, out_last, out_sum, out_vec_id, out_node);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
    vectors++;
    if (frames_done !== 16'h0) begin
      errors++;
      $display("FAIL reset frames_done: got %h want 0000", frames_done);
    end
  endtask

  task automatic test_reset_mid_drain();
    exp_t e;
    fill_random();
    out_ready = 1'b1;
    put_frame(31'h3);
    step();
    in_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (!out_valid || {out_sum, out_vec_id, out_node, out_last} !== e) begin
      errors++;
      $display("FAIL mid_drain first: got v=%b %h want %h", out_valid,
               {out_sum, out_vec_id, out_node, out_last}, e);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    vectors++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_sum !== '0 || out_node !== '0) begin
      errors++;
      $display("FAIL mid_drain cleared: got valid=%b last=%b sum=%h node=%h want 0", out_valid,
               out_last, out_sum, out_node);
    end
    vectors++;
    if (in_ready !== 1'b1 || frames_done !== exp_done) begin
      errors++;
      $display("FAIL mid_drain state: got in_ready=%b frames_done=%h want 1 %h", in_ready,
               frames_done, exp_done);
    end
  endtask

  task automatic test_single();
    exp_t e;
    fill_random();
    f_sum[0] = 13'd10; f_id[0] = 3'd1;
    f_sum[5] = 13'd20; f_id[5] = 3'd2;
    f_sum[30] = 13'd30; f_id[30] = 3'd3;
    out_ready = 1'b1;
    put_frame(31'h4000_0021);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      vectors++;
      if (!out_valid || {out_sum, out_vec_id, out_node, out_last} !== e) begin
        errors++;
        $display("FAIL single result %0d: got v=%b sum=%h id=%h node=%0d last=%b want %h", c,
                 out_valid, out_sum, out_vec_id, out_node, out_last, e);
      end
      step();
    end
    exp_done = exp_done + 16'd1;
    vectors++;
    if (out_valid !== 1'b0 || frames_done !== exp_done) begin
      errors++;
      $display("FAIL single end: got valid=%b frames_done=%h want 0 %h", out_valid, frames_done,
               exp_done);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    put_frame(31'h4000_0021);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (!out_valid || {out_sum, out_vec_id, out_node, out_last} !== e) begin
      errors++;
      $display("FAIL backpressure first: got %h want %h",
               {out_sum, out_vec_id, out_node, out_last}, e);
    end
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (!out_valid || in_ready !== 1'b0 || {out_sum, out_vec_id, out_node, out_last} !== sb[0]) begin
        errors++;
        $display("FAIL backpressure hold %0d: got v=%b in_ready=%b %h want v=1 in_ready=0 %h", c,
                 out_valid, in_ready, {out_sum, out_vec_id, out_node, out_last}, sb[0]);
      end
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      if (out_valid) begin
        e = sb.pop_front();
        vectors++;
        if ({out_sum, out_vec_id, out_node, out_last} !== e) begin
          errors++;
          $display("FAIL backpressure drain: got %h want %h",
                   {out_sum, out_vec_id, out_node, out_last}, e);
        end
      end
      step();
    end
    exp_done = exp_done + 16'd1;
    vectors++;
    if (sb.size() != 0 || frames_done !== exp_done) begin
      errors++;
      $display("FAIL backpressure end: got left=%0d frames_done=%h want 0 %h", sb.size(),
               frames_done, exp_done);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    put_frame(31'h4000_0021);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e = sb.pop_front();
      vectors++;
      if (!out_valid || {out_sum, out_vec_id, out_node, out_last} !== e) begin
        errors++;
        $display("FAIL back_to_back result %0d: got v=%b %h want %h", c, out_valid,
                 {out_sum, out_vec_id, out_node, out_last}, e);
      end
      if (c == 2) begin
        fill_random();
        f_sum[2] = 13'h1FFF;
        f_id[2]  = 3'd7;
        put_frame(31'h4);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back in_ready: got %b want 1", in_ready);
        end
      end
      step();
      in_valid = 1'b0;
    end
    exp_done = exp_done + 16'd2;
    vectors++;
    if (out_valid !== 1'b0 || frames_done !== exp_done) begin
      errors++;
      $display("FAIL back_to_back end: got valid=%b frames_done=%h want 0 %h", out_valid,
               frames_done, exp_done);
    end
  endtask

  task automatic test_empty();
    fill_random();
    put_frame('0);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty in_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (out_valid !== 1'b0 || frames_done !== exp_done) begin
        errors++;
        $display("FAIL empty cycle %0d: got valid=%b frames_done=%h want 0 %h", c, out_valid,
                 frames_done, exp_done);
      end
      step();
    end
  endtask

  task automatic test_full_wrap();
    exp_t e;
    int   lasts;
    lasts = 0;
    force dut.frames_done = 16'hFFFF;
    #1;
    release dut.frames_done;
    exp_done = 16'hFFFF;
    vectors++;
    if (frames_done !== exp_done) begin
      errors++;
      $display("FAIL wrap preload: got %h want ffff", frames_done);
    end
    fill_random();
    out_ready = 1'b1;
    put_frame(31'h7FFF_FFFF);
    step();
    in_valid  = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      #1;
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        if (out_last) lasts++;
        vectors++;
        if ({out_sum, out_vec_id, out_node, out_last} !== e) begin
          errors++;
          $display("FAIL full result: got sum=%h id=%h node=%0d last=%b want %h", out_sum,
                   out_vec_id, out_node, out_last, e);
        end
      end
      step();
      out_ready = 1'($urandom_range(0, 1));
    end
    exp_done = exp_done + 16'd1;
    vectors++;
    if (sb.size() != 0 || lasts != 1) begin
      errors++;
      $display("FAIL full drain: got left=%0d lasts=%0d want 0 1", sb.size(), lasts);
      sb.delete();
    end
    vectors++;
    if (out_valid !== 1'b0 || frames_done !== exp_done) begin
      errors++;
      $display("FAIL full wrap: got valid=%b frames_done=%h want 0 %h", out_valid, frames_done,
               exp_done);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sums    = '0;
    in_valids  = '0;
    in_vec_ids = '0;
    out_ready  = 1'b0;
    test_reset();
    test_reset_mid_drain();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_empty();
    test_full_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
